// File: rtl/ctrl_sequencer_if.sv
// Command handshake plus the per-cycle drive stream toward the load/double/increment register.
// The master side offers commands; the slave side is the sequencer itself.
interface ctrl_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic [3:0] data_in;
  logic [2:0] control;
  logic       busy;
  logic       done;
  logic [3:0] exp_value;

  modport master (
    output cmd_valid, cmd_op, cmd_arg,
    input  cmd_ready, data_in, control, busy, done, exp_value
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg,
    output cmd_ready, data_in, control, busy, done, exp_value
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Buffers high-level commands in a FIFO and expands each one into per-cycle data_in/control steps,
// while tracking a shadow copy of the downstream register value.
module ctrl_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ctrl_sequencer_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic { IDLE, RUN } state_t;
  typedef enum logic [1:0] {
    OP_LOAD        = 2'b00,
    OP_LOAD_DOUBLE = 2'b01,
    OP_INC         = 2'b10,
    OP_HOLD        = 2'b11
  } op_t;

  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;

  state_t        state_q;
  logic [4:0]    stepCnt_q;
  logic [3:0]    dataIn_q;
  logic [2:0]    control_q;
  logic          done_q;
  logic [3:0]    expValue_q;

  logic          full, empty, push, pop, lastStep;
  op_t           headOp;
  logic [3:0]    headArg;
  logic [4:0]    headSteps;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign push     = bus.cmd_valid && !full;
  assign lastStep = (state_q == RUN) && (stepCnt_q == 5'd1);
  assign pop      = !empty && ((state_q == IDLE) || lastStep);

  assign headOp   = op_t'(mem_q[rdPtr_q][5:4]);
  assign headArg  = mem_q[rdPtr_q][3:0];

  // Loads are single-step; INC/HOLD repeat arg times, with zero standing for 16.
  always_comb begin
    headSteps = 5'd1;
    if (headOp == OP_INC || headOp == OP_HOLD) begin
      headSteps = (headArg == 4'd0) ? 5'd16 : {1'b0, headArg};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {bus.cmd_op, bus.cmd_arg};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push && pop) count_q <= count_q - (AW+1)'(1);
    end
  end

  // The shadow register samples the step being driven now, so it trails control by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      stepCnt_q  <= '0;
      dataIn_q   <= '0;
      control_q  <= '0;
      done_q     <= 1'b0;
      expValue_q <= '0;
    end else begin
      if (control_q[0]) begin
        if (control_q[2])      expValue_q <= expValue_q + 4'd1;
        else if (control_q[1]) expValue_q <= {dataIn_q[2:0], 1'b0};
        else                   expValue_q <= dataIn_q;
      end

      if (pop) begin
        state_q   <= RUN;
        stepCnt_q <= headSteps;
        done_q    <= (headSteps == 5'd1);
        unique case (headOp)
          OP_LOAD:        begin control_q <= 3'b001; dataIn_q <= headArg; end
          OP_LOAD_DOUBLE: begin control_q <= 3'b011; dataIn_q <= headArg; end
          OP_INC:         begin control_q <= 3'b101; dataIn_q <= 4'd0;    end
          OP_HOLD:        begin control_q <= 3'b000; dataIn_q <= 4'd0;    end
        endcase
      end else if (state_q == RUN && !lastStep) begin
        stepCnt_q <= stepCnt_q - 5'd1;
        done_q    <= (stepCnt_q == 5'd2);
      end else if (state_q == RUN) begin
        state_q   <= IDLE;
        stepCnt_q <= '0;
        control_q <= 3'b000;
        dataIn_q  <= 4'd0;
        done_q    <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = !full;
  assign bus.data_in   = dataIn_q;
  assign bus.control   = control_q;
  assign bus.busy      = (state_q == RUN) || !empty;
  assign bus.done      = done_q;
  assign bus.exp_value = expValue_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: a table of per-cycle vectors for the short commands,
// followed by hand-written sequences for 16-step commands, FIFO backpressure and mid-command reset.
module tb_ctrl_sequencer;

  typedef struct {
    logic       valid;
    logic [1:0] op;
    logic [3:0] arg;
    logic [2:0] ctl;
    logic [3:0] data;
    logic       done;
    logic [3:0] expv;
    logic       busy;
    logic       ready;
  } vec_t;

  localparam logic [1:0] LOAD = 2'b00, LDBL = 2'b01, INC = 2'b10, HOLD = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [13];

  ctrl_sequencer_if bus ();

  ctrl_sequencer #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Drive one table row across one clock edge and compare every output afterwards.
  task automatic applyStimulus(input int idx, input vec_t v);
    bus.cmd_valid = v.valid;
    bus.cmd_op    = v.op;
    bus.cmd_arg   = v.arg;
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d.control", idx),   8'(bus.control),   8'(v.ctl));
    checkOutput($sformatf("v%0d.data_in", idx),   8'(bus.data_in),   8'(v.data));
    checkOutput($sformatf("v%0d.done", idx),      8'(bus.done),      8'(v.done));
    checkOutput($sformatf("v%0d.exp_value", idx), 8'(bus.exp_value), 8'(v.expv));
    checkOutput($sformatf("v%0d.busy", idx),      8'(bus.busy),      8'(v.busy));
    checkOutput($sformatf("v%0d.cmd_ready", idx), 8'(bus.cmd_ready), 8'(v.ready));
  endtask

  task automatic pushCmd(input logic [1:0] op, input logic [3:0] arg);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_arg   = 4'h0;

    //          valid op    arg    ctl     data  done  exp   busy  ready
    vecs[0]  = '{1'b1, LOAD, 4'h9, 3'b000, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, LOAD, 4'h0, 3'b001, 4'h9, 1'b1, 4'h0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, LOAD, 4'h0, 3'b000, 4'h0, 1'b0, 4'h9, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, LDBL, 4'hB, 3'b000, 4'h0, 1'b0, 4'h9, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, LOAD, 4'h0, 3'b011, 4'hB, 1'b1, 4'h9, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, LOAD, 4'h0, 3'b000, 4'h0, 1'b0, 4'h6, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, LOAD, 4'hE, 3'b000, 4'h0, 1'b0, 4'h6, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, INC,  4'h3, 3'b001, 4'hE, 1'b1, 4'h6, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, HOLD, 4'h5, 3'b101, 4'h0, 1'b0, 4'hE, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, LOAD, 4'h0, 3'b101, 4'h0, 1'b0, 4'hF, 1'b1, 1'b1};
    vecs[10] = '{1'b0, LOAD, 4'h0, 3'b101, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, LOAD, 4'h0, 3'b000, 4'h0, 1'b0, 4'h1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, LOAD, 4'h0, 3'b000, 4'h0, 1'b0, 4'h1, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.control",   8'(bus.control),   8'h0);
    checkOutput("reset.data_in",   8'(bus.data_in),   8'h0);
    checkOutput("reset.done",      8'(bus.done),      8'h0);
    checkOutput("reset.exp_value", 8'(bus.exp_value), 8'h0);
    checkOutput("reset.busy",      8'(bus.busy),      8'h0);
    checkOutput("reset.cmd_ready", 8'(bus.cmd_ready), 8'h1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) applyStimulus(i, vecs[i]);

    // INC by 16 from 5 wraps all the way round to 5.
    pushCmd(LOAD, 4'h5);
    pushCmd(INC, 4'h0);
    checkOutput("inc16.load.control", 8'(bus.control), 8'h1);
    checkOutput("inc16.load.data_in", 8'(bus.data_in), 8'h5);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("inc16.step%0d.control", i), 8'(bus.control), 8'h5);
      checkOutput($sformatf("inc16.step%0d.done", i), 8'(bus.done), (i == 15) ? 8'h1 : 8'h0);
    end
    @(posedge clk);
    #1;
    checkOutput("inc16.end.control",   8'(bus.control),   8'h0);
    checkOutput("inc16.end.exp_value", 8'(bus.exp_value), 8'h5);
    checkOutput("inc16.end.busy",      8'(bus.busy),      8'h0);

    // HOLD by 16 keeps busy high with an all-zero control word.
    pushCmd(HOLD, 4'h0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold16.step%0d.control", i), 8'(bus.control), 8'h0);
      checkOutput($sformatf("hold16.step%0d.busy", i), 8'(bus.busy), 8'h1);
      checkOutput($sformatf("hold16.step%0d.done", i), 8'(bus.done), (i == 15) ? 8'h1 : 8'h0);
    end
    @(posedge clk);
    #1;
    checkOutput("hold16.end.busy",      8'(bus.busy),      8'h0);
    checkOutput("hold16.end.exp_value", 8'(bus.exp_value), 8'h5);

    // Fill the FIFO behind a long HOLD, then offer one more command that must be refused.
    pushCmd(HOLD, 4'h0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("fill%0d.cmd_ready", k), 8'(bus.cmd_ready), 8'h1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = LOAD;
      bus.cmd_arg   = 4'(k + 1);
      @(posedge clk);
      #1;
    end
    checkOutput("full.cmd_ready", 8'(bus.cmd_ready), 8'h0);
    bus.cmd_arg = 4'h7;
    @(posedge clk);
    #1;
    checkOutput("refused.cmd_ready", 8'(bus.cmd_ready), 8'h0);
    bus.cmd_valid = 1'b0;
    begin
      bit found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(posedge clk);
        #1;
        if (bus.control == 3'b001) found = 1'b1;
      end
      checkOutput("drain.firstPopSeen", 8'(found), 8'h1);
    end
    checkOutput("drain.first.cmd_ready", 8'(bus.cmd_ready), 8'h1);
    checkOutput("drain.first.data_in",   8'(bus.data_in),   8'h1);
    checkOutput("drain.first.done",      8'(bus.done),      8'h1);
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("drain%0d.control", k), 8'(bus.control), 8'h1);
      checkOutput($sformatf("drain%0d.data_in", k), 8'(bus.data_in), 8'(k));
    end
    @(posedge clk);
    #1;
    checkOutput("drain.end.control",   8'(bus.control),   8'h0);
    checkOutput("drain.end.busy",      8'(bus.busy),      8'h0);
    checkOutput("drain.end.exp_value", 8'(bus.exp_value), 8'h4);

    // Reset in the middle of an INC with two commands waiting behind it.
    pushCmd(INC, 4'h8);
    @(posedge clk);
    #1;
    pushCmd(LOAD, 4'hA);
    pushCmd(LOAD, 4'hB);
    checkOutput("preReset.control", 8'(bus.control), 8'h5);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.control",   8'(bus.control),   8'h0);
    checkOutput("midReset.data_in",   8'(bus.data_in),   8'h0);
    checkOutput("midReset.done",      8'(bus.done),      8'h0);
    checkOutput("midReset.exp_value", 8'(bus.exp_value), 8'h0);
    checkOutput("midReset.cmd_ready", 8'(bus.cmd_ready), 8'h1);
    checkOutput("midReset.busy",      8'(bus.busy),      8'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int stale = 0;
      for (int c = 0; c < 30; c++) begin
        @(posedge clk);
        #1;
        if (bus.control != 3'b000 || bus.busy || bus.done) stale++;
      end
      checkOutput("postReset.staleCycles", 8'(stale), 8'h0);
    end
    checkOutput("postReset.exp_value", 8'(bus.exp_value), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
